// File: rtl/pong_pkg.sv
// Shared definitions for the pong input path: button indices, timing presets,
// channel state encoding and a small index helper.
package pong_pkg;

    localparam int BTN_P1_UP = 0;
    localparam int BTN_P1_DN = 1;
    localparam int BTN_P2_UP = 2;
    localparam int BTN_P2_DN = 3;

    // 100 MHz board: 10 ms debounce, 400 ms initial hold, 100 ms repeat (needs CNT_W >= 26)
    localparam int DB_CYCLES_HW     = 1_000_000;
    localparam int HOLD_CYCLES_HW   = 40_000_000;
    localparam int REPEAT_CYCLES_HW = 10_000_000;

    localparam int DB_CYCLES_SIM     = 4;
    localparam int HOLD_CYCLES_SIM   = 20;
    localparam int REPEAT_CYCLES_SIM = 8;

    typedef enum logic [1:0] {
        CH_RELEASED = 2'd0,
        CH_HOLD     = 2'd1,
        CH_REPEAT   = 2'd2
    } ch_state_t;

    function automatic int unsigned wrap_inc(input int unsigned i, input int unsigned n);
        return (i + 32'd1 >= n) ? 32'd0 : i + 32'd1;
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One button: 2-flop synchronizer, debounce, and press/hold/repeat event FSM.
// ev_pulse is combinational so the parent can register it straight into pending.
module btn_channel
    import pong_pkg::*;
#(
    parameter int DB_CYCLES     = 4,
    parameter int HOLD_CYCLES   = 20,
    parameter int REPEAT_CYCLES = 8,
    parameter int CNT_W         = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic ev_pulse,
    output logic ev_rep
);

    localparam int DB_W = $clog2(DB_CYCLES + 1);

    logic [1:0]       sync_reg;
    logic [DB_W-1:0]  db_cnt_reg;
    logic             level_reg;
    ch_state_t        state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_reg   <= '0;
            db_cnt_reg <= '0;
            level_reg  <= 1'b0;
            state_reg  <= CH_RELEASED;
            cnt_reg    <= '0;
        end else begin
            sync_reg  <= {sync_reg[0], raw};
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            // any agreeing sample restarts the stability count
            if (sync_reg[1] == level_reg) begin
                db_cnt_reg <= '0;
            end else if (db_cnt_reg == DB_W'(DB_CYCLES - 1)) begin
                level_reg  <= ~level_reg;
                db_cnt_reg <= '0;
            end else begin
                db_cnt_reg <= db_cnt_reg + 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        ev_pulse   = 1'b0;
        ev_rep     = 1'b0;
        case (state_reg)
            CH_RELEASED: begin
                if (level_reg) begin
                    ev_pulse   = 1'b1;
                    cnt_next   = '0;
                    state_next = CH_HOLD;
                end
            end
            CH_HOLD: begin
                if (!level_reg) begin
                    cnt_next   = '0;
                    state_next = CH_RELEASED;
                end else if (cnt_reg == CNT_W'(HOLD_CYCLES - 1)) begin
                    ev_pulse   = 1'b1;
                    ev_rep     = 1'b1;
                    cnt_next   = '0;
                    state_next = CH_REPEAT;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            CH_REPEAT: begin
                if (!level_reg) begin
                    cnt_next   = '0;
                    state_next = CH_RELEASED;
                end else if (cnt_reg == CNT_W'(REPEAT_CYCLES - 1)) begin
                    ev_pulse = 1'b1;
                    ev_rep   = 1'b1;
                    cnt_next = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                cnt_next   = '0;
                state_next = CH_RELEASED;
            end
        endcase
    end

    assign level = level_reg;

endmodule

// File: rtl/pong_btn_sched.sv
// Button front end for pong: per-button channels feed coalescing pending bits,
// which a round-robin arbiter drains into one valid/ready event register.
module pong_btn_sched
    import pong_pkg::*;
#(
    parameter int N_BTN         = 4,
    parameter int DB_CYCLES     = 4,
    parameter int HOLD_CYCLES   = 20,
    parameter int REPEAT_CYCLES = 8,
    parameter int CNT_W         = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic [N_BTN-1:0]         btn_raw,
    output logic [N_BTN-1:0]         btn_level,
    output logic                     ev_valid,
    input  logic                     ev_ready,
    output logic [$clog2(N_BTN)-1:0] ev_id,
    output logic                     ev_repeat
);

    localparam int ID_W = $clog2(N_BTN);

    logic [N_BTN-1:0] ch_pulse, ch_rep;
    logic [N_BTN-1:0] pend_reg, pend_next, prep_reg, prep_next, pend_eff;
    logic [ID_W-1:0]  rr_reg, ev_id_reg, win;
    logic             ev_valid_reg, ev_rep_reg, found, load;
    int               sel_idx;

    generate
        for (genvar gi = 0; gi < N_BTN; gi++) begin : g_ch
            btn_channel #(
                .DB_CYCLES    (DB_CYCLES),
                .HOLD_CYCLES  (HOLD_CYCLES),
                .REPEAT_CYCLES(REPEAT_CYCLES),
                .CNT_W        (CNT_W)
            ) u_ch (
                .clk     (clk),
                .rst     (rst),
                .raw     (btn_raw[gi]),
                .level   (btn_level[gi]),
                .ev_pulse(ch_pulse[gi]),
                .ev_rep  (ch_rep[gi])
            );
        end
    endgenerate

    assign load     = !ev_valid_reg || ev_ready;
    assign pend_eff = enable ? pend_reg : '0;

    // first pending channel at or after the rr pointer
    always_comb begin
        found   = 1'b0;
        win     = '0;
        sel_idx = 0;
        for (int k = 0; k < N_BTN; k++) begin
            sel_idx = int'(rr_reg) + k;
            if (sel_idx >= N_BTN) sel_idx = sel_idx - N_BTN;
            if (!found && pend_eff[sel_idx]) begin
                found = 1'b1;
                win   = ID_W'(sel_idx);
            end
        end
    end

    // consumption is applied before new events so a same-cycle event re-arms the bit
    always_comb begin
        pend_next = pend_reg;
        prep_next = prep_reg;
        if (load && found) pend_next[win] = 1'b0;
        for (int k = 0; k < N_BTN; k++) begin
            if (ch_pulse[k]) begin
                prep_next[k] = pend_next[k] ? (prep_reg[k] & ch_rep[k]) : ch_rep[k];
                pend_next[k] = 1'b1;
            end
        end
        if (!enable) pend_next = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_reg     <= '0;
            prep_reg     <= '0;
            rr_reg       <= '0;
            ev_valid_reg <= 1'b0;
            ev_id_reg    <= '0;
            ev_rep_reg   <= 1'b0;
        end else begin
            pend_reg <= pend_next;
            prep_reg <= prep_next;
            if (load) begin
                ev_valid_reg <= found;
                if (found) begin
                    ev_id_reg  <= win;
                    ev_rep_reg <= prep_reg[win];
                    rr_reg     <= ID_W'(wrap_inc(32'(win), N_BTN));
                end
            end
        end
    end

    assign ev_valid  = ev_valid_reg;
    assign ev_id     = ev_id_reg;
    assign ev_repeat = ev_rep_reg;

endmodule

// File: tb/tb_pong_btn_sched.sv
// Directed bench for pong_btn_sched: stimulus pushes expected events (id, repeat,
// acceptance cycle) into a queue; a monitor pops and compares each accepted event.
module tb_pong_btn_sched;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         enable;
    logic [N-1:0] btn_raw;
    logic [N-1:0] btn_level;
    logic         ev_valid;
    logic         ev_ready;
    logic [1:0]   ev_id;
    logic         ev_repeat;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int id;
        int rep;
        int cyc;
    } exp_t;
    exp_t exp_q[$];

    pong_btn_sched #(
        .N_BTN(N), .DB_CYCLES(4), .HOLD_CYCLES(20), .REPEAT_CYCLES(8), .CNT_W(16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .btn_raw  (btn_raw),
        .btn_level(btn_level),
        .ev_valid (ev_valid),
        .ev_ready (ev_ready),
        .ev_id    (ev_id),
        .ev_repeat(ev_repeat)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (cyc %0d)", name, act, req, cyc);
        end else begin
            $display("check %s = %0d ok (cyc %0d)", name, act, cyc);
        end
    endtask

    task automatic expect_ev(input int id, input int rep, input int c);
        exp_t e;
        e.id = id; e.rep = rep; e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // monitor: compares every accepted event, and checks stalled outputs stay put
    logic stall_prev = 1'b0;
    int   prev_id = 0, prev_rep = 0;
    always begin
        exp_t e;
        @(negedge clk);
        #1;
        if (!rst) begin
            stall_prev = 1'b0;
        end else begin
            if (ev_valid && ev_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: got id=%0d rep=%0d cyc=%0d, required no event",
                             ev_id, ev_repeat, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (int'(ev_id) != e.id || int'(ev_repeat) != e.rep || cyc != e.cyc) begin
                        errors++;
                        $display("FAIL event: got id=%0d rep=%0d cyc=%0d, required id=%0d rep=%0d cyc=%0d",
                                 ev_id, ev_repeat, cyc, e.id, e.rep, e.cyc);
                    end else begin
                        $display("event id=%0d rep=%0d cyc=%0d ok", ev_id, ev_repeat, cyc);
                    end
                end
            end else if (ev_valid && stall_prev) begin
                checks++;
                if (int'(ev_id) != prev_id || int'(ev_repeat) != prev_rep) begin
                    errors++;
                    $display("FAIL stall_stable: got id=%0d rep=%0d, required id=%0d rep=%0d",
                             ev_id, ev_repeat, prev_id, prev_rep);
                end
            end
            stall_prev = ev_valid && !ev_ready;
            prev_id    = int'(ev_id);
            prev_rep   = int'(ev_repeat);
        end
    end

    initial begin
        int t0;
        int t1;
        rst      = 1'b0;
        enable   = 1'b1;
        btn_raw  = '0;
        ev_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ev_valid", int'(ev_valid), 0);
        chk("rst_ev_id", int'(ev_id), 0);
        chk("rst_ev_repeat", int'(ev_repeat), 0);
        chk("rst_btn_level", int'(btn_level), 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // single press on button 1: level at edge 6, event at edge 8
        t0 = cyc;
        btn_raw[1] = 1'b1;
        expect_ev(1, 0, t0 + 8);
        wait_cyc(t0 + 5);
        chk("p1_level_before", int'(btn_level[1]), 0);
        wait_cyc(t0 + 6);
        chk("p1_level_edge6", int'(btn_level[1]), 1);
        wait_cyc(t0 + 10);
        btn_raw[1] = 1'b0;
        wait_cyc(t0 + 30);

        // glitches on button 0 never reach the debounced level
        t0 = cyc;
        btn_raw[0] = 1'b1;
        wait_cyc(t0 + 2); btn_raw[0] = 1'b0;
        wait_cyc(t0 + 3); btn_raw[0] = 1'b1;
        wait_cyc(t0 + 6); btn_raw[0] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            wait_cyc(t0 + 2 + 2 * i);
            chk("glitch_level0", int'(btn_level[0]), 0);
        end
        wait_cyc(t0 + 20);

        // button 2 held 60 cycles: press then five repeats, none after release
        t0 = cyc;
        btn_raw[2] = 1'b1;
        expect_ev(2, 0, t0 + 8);
        for (int i = 0; i < 5; i++) expect_ev(2, 1, t0 + 28 + 8 * i);
        wait_cyc(t0 + 60);
        btn_raw[2] = 1'b0;
        wait_cyc(t0 + 90);
        chk("hold_level2_released", int'(btn_level[2]), 0);

        // press button 3 while disabled: only the first repeat is reported
        t0 = cyc;
        enable = 1'b0;
        btn_raw[3] = 1'b1;
        wait_cyc(t0 + 10);
        chk("dis_level3", int'(btn_level[3]), 1);
        chk("dis_no_valid", int'(ev_valid), 0);
        enable = 1'b1;
        expect_ev(3, 1, t0 + 28);
        wait_cyc(t0 + 28);
        btn_raw[3] = 1'b0;
        wait_cyc(t0 + 50);

        // all four at once with a 10-cycle stall, then drained round-robin
        t0 = cyc;
        ev_ready = 1'b0;
        btn_raw  = '1;
        for (int i = 0; i < 4; i++) expect_ev(i, 0, t0 + 10 + i);
        wait_cyc(t0 + 8);
        chk("stall_valid_e8", int'(ev_valid), 1);
        chk("stall_id_e8", int'(ev_id), 0);
        wait_cyc(t0 + 9);
        chk("stall_id_e9", int'(ev_id), 0);
        wait_cyc(t0 + 10);
        ev_ready = 1'b1;
        wait_cyc(t0 + 12);
        btn_raw = '0;
        wait_cyc(t0 + 35);

        // async reset drops an unaccepted event; a fresh press follows release
        t0 = cyc;
        ev_ready = 1'b0;
        btn_raw[1] = 1'b1;
        wait_cyc(t0 + 9);
        chk("prereset_valid", int'(ev_valid), 1);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_valid", int'(ev_valid), 0);
        chk("async_rst_level", int'(btn_level), 0);
        chk("async_rst_pending", int'(dut.pend_reg), 0);
        @(negedge clk);
        t1 = cyc;
        rst = 1'b1;
        ev_ready = 1'b1;
        expect_ev(1, 0, t1 + 8);
        wait_cyc(t1 + 10);
        btn_raw[1] = 1'b0;
        wait_cyc(t1 + 30);

        #2;
        chk("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pong_btn_sched.md
Name: pong_btn_sched

Overview:
- Input-side controller for the pong game. Takes N raw push buttons (paddle up/down for both players) and drives one shared debounce/one-pulse path per button.
- Adds hold-to-auto-repeat for each button.
- Arbitrates the resulting press/repeat events round-robin onto a single valid/ready event stream consumed by the game FSM.

Parameters:
- N_BTN, 4, number of buttons (2..8)
- DB_CYCLES, 4, consecutive stable synchronized samples required to change a debounced level
- HOLD_CYCLES, 20, cycles a button must stay held after press before the first repeat
- REPEAT_CYCLES, 8, cycles between subsequent repeats while held
- CNT_W, 16, width of per-channel hold/repeat counter (must hold max(HOLD_CYCLES, REPEAT_CYCLES))

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset; 0 = reset
- enable  in  1  1 = event generation on; 0 = suppress and flush pending events
- btn_raw  in  N_BTN  raw asynchronous button inputs, 1 = pressed
- btn_level  out  N_BTN  debounced button levels
- ev_valid  out  1  event available
- ev_ready  in  1  consumer accepts event when ev_valid & ev_ready at a rising edge
- ev_id  out  clog2(N_BTN)  index of the button that produced the event
- ev_repeat  out  1  0 = initial press, 1 = auto-repeat

Behaviour:
- Reset (rst=0, async): sync flops, btn_level, debounce counters, hold counters, pending bits, rr pointer all 0. Channel FSMs go to RELEASED. ev_valid=0, ev_id=0, ev_repeat=0.
- Per-channel pipeline:
  - Edges 1–2: 2-flop synchronizer.
  - Debounce counter increments each cycle the sync output differs from btn_level. It clears on any cycle they match.
  - When the counter reaches DB_CYCLES, btn_level toggles and the counter clears.
  - A glitch shorter than DB_CYCLES synchronized cycles never changes btn_level.
- Channel FSM (RELEASED, HOLD, REPEAT):
  - RELEASED: btn_level 0→1 → set pending with rep=0, clear hold counter, go HOLD.
  - HOLD: counter increments each cycle. At counter == HOLD_CYCLES-1: set pending with rep=1, clear counter, go REPEAT.
  - REPEAT: at counter == REPEAT_CYCLES-1: set pending with rep=1, clear counter.
  - btn_level 1→0 in HOLD or REPEAT → RELEASED, clear counter. The pending bit is not cleared.
- Pending coalescing: one pending bit plus rep flag per channel.
  - New event while pending is already set: bit stays set.
  - rep = rep_old AND rep_new, so a press is never downgraded to a repeat.
- Arbiter/output register:
  - Loads when ev_valid=0 or (ev_valid & ev_ready).
  - Winner = first pending channel at or after rr pointer, wrapping modulo N_BTN.
  - On load: ev_valid=1, ev_id=winner, ev_repeat=rep[winner], pending[winner] cleared, rr pointer = winner+1 mod N_BTN.
  - No pending channel at load → ev_valid=0.
  - ev_id and ev_repeat are held stable while ev_valid & !ev_ready.
- Simultaneous events:
  - A new event on a channel in the same cycle its pending bit is consumed re-sets pending (the new event wins).
  - Multiple channels pending at once are served strictly round-robin, one per accepted transfer.
- Latency: raw rising edge held stable → btn_level rises on edge DB_CYCLES+2 → pending on edge DB_CYCLES+3 → ev_valid on edge DB_CYCLES+4 (output register idle).
- Throughput: one event per cycle with ev_ready held at 1.
- enable=0:
  - Channel FSMs keep tracking btn_level, but no pending bits are set.
  - All pending bits clear.
  - An event already in the output register stays valid until accepted.
- Reset mid-operation: everything returns to reset values immediately, including a valid unaccepted event (dropped).

Decomposition:
- Shared package pong_pkg:
  - constants BTN_P1_UP=0, BTN_P1_DN=1, BTN_P2_UP=2, BTN_P2_DN=3
  - default timing constants DB_CYCLES/HOLD_CYCLES/REPEAT_CYCLES for 100 MHz, and simulation values
  - channel FSM state encoding (RELEASED=0, HOLD=1, REPEAT=2)
- Sub-module btn_channel, instantiated N_BTN times: synchronizer, debounce, FSM, counters. Outputs level, ev_pulse, ev_rep.
- The top holds pending bits, round-robin arbiter and output register.

Test Plan (DB_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=8, N_BTN=4):
- Reset, then btn_raw[1] 0→1 held, ev_ready=1 → btn_level[1]=1 at edge 6; one-cycle ev_valid at edge 8 with ev_id=1, ev_repeat=0.
- btn_raw[0] glitches: high 2 cycles, low 1, high 3, low → btn_level[0] stays 0, no ev_valid ever.
- btn_raw[2] held 60 cycles → press event, then ev_repeat=1 events for id 2 at +20, +28, +36, +44, +52 cycles after the press pending. None after release.
- All four buttons rise on the same cycle, ev_ready=0 for 10 cycles then 1 → ev_valid held with id 0 stable; on release of ev_ready, ids 0,1,2,3 on consecutive cycles, all ev_repeat=0.
- Press button 3 with enable=0, then set enable=1 while still held → no press event; first event is a repeat (id 3, ev_repeat=1) at HOLD_CYCLES.
- Assert rst=0 while ev_valid=1 and button held → ev_valid, btn_level and pending drop to 0 asynchronously. After rst=1 with the button still held, a fresh press event appears DB_CYCLES+4 edges later.
